// File: rtl/ram_burst_reader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ram_burst_reader : burst read sequencer for a 1-cycle-latency SDP RAM
// Rev 1.0
// ---------------------------------------------------------------------------
module ram_burst_reader #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              Start,
  input  logic [ADDR_W-1:0] StartAddr,
  input  logic [ADDR_W:0]   Len,
  input  logic              Abort,
  output logic              Busy,
  output logic              Done,
  output logic [ADDR_W-1:0] RA,
  output logic              RClk_En,
  input  logic [DATA_W-1:0] RD,
  output logic [DATA_W-1:0] Out_Data,
  output logic              Out_Valid,
  input  logic              Out_Ready,
  output logic              Out_Last
);

  localparam logic [ADDR_W:0]   c_max_len  = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   c_len_one  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]   c_len_zero = '0;
  localparam logic [ADDR_W-1:0] c_addr_one = ADDR_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W:0]   r_issue_cnt;
  logic [ADDR_W:0]   r_deliv_cnt;
  logic              r_inflight;

  logic [DATA_W-1:0] r_fifo [2];
  logic              r_wr_ptr;
  logic              r_rd_ptr;
  logic [1:0]        r_fifo_cnt;

  logic [ADDR_W:0]   w_len_sat;
  logic              w_pop;
  logic              w_push;
  logic              w_issue;
  logic              w_last;
  logic [2:0]        w_occ;
  logic              w_accept;

  assign w_len_sat = (Len > c_max_len) ? c_max_len : Len;
  assign w_accept  = (r_state == S_IDLE) && Start && !Abort;

  assign Out_Valid = (r_fifo_cnt != 2'd0);
  assign Out_Data  = r_fifo[r_rd_ptr];
  assign w_pop     = Out_Valid && Out_Ready;
  assign w_push    = r_inflight;
  assign w_last    = Out_Valid && (r_deliv_cnt == c_len_one);
  assign Out_Last  = w_last;
  assign RA        = r_addr;

  // Words held or returning after this edge; issuing only while it stays below 2
  // keeps the 2-entry FIFO from overflowing without a skid buffer.
  assign w_occ = {1'b0, r_fifo_cnt} + {2'b00, r_inflight} - {2'b00, w_pop};

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    Busy        = 1'b0;
    Done        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (Start) begin
          w_state_nxt = (Len == c_len_zero) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        Busy    = 1'b1;
        w_issue = (r_issue_cnt != c_len_zero) && (w_occ < 3'd2);
        if (w_pop && w_last) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        Busy        = 1'b1;
        Done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    if (Abort) begin
      w_state_nxt = S_IDLE;
    end
  end

  assign RClk_En = w_issue;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_addr      <= '0;
      r_issue_cnt <= '0;
      r_deliv_cnt <= '0;
      r_inflight  <= 1'b0;
    end else if (Abort) begin
      r_addr      <= '0;
      r_issue_cnt <= '0;
      r_deliv_cnt <= '0;
      r_inflight  <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (w_accept) begin
        r_addr      <= StartAddr;
        r_issue_cnt <= w_len_sat;
        r_deliv_cnt <= w_len_sat;
      end else begin
        if (w_issue) begin
          r_addr      <= r_addr + c_addr_one;
          r_issue_cnt <= r_issue_cnt - c_len_one;
        end
        if (w_pop) begin
          r_deliv_cnt <= r_deliv_cnt - c_len_one;
        end
      end
    end
  end

  // Output FIFO; a read still returning when Abort hits is simply never pushed.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_fifo[0]  <= '0;
      r_fifo[1]  <= '0;
      r_wr_ptr   <= 1'b0;
      r_rd_ptr   <= 1'b0;
      r_fifo_cnt <= 2'd0;
    end else if (Abort) begin
      r_wr_ptr   <= 1'b0;
      r_rd_ptr   <= 1'b0;
      r_fifo_cnt <= 2'd0;
    end else begin
      if (w_push) begin
        r_fifo[r_wr_ptr] <= RD;
        r_wr_ptr         <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_fifo_cnt <= r_fifo_cnt + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ram_burst_reader.sv
`default_nettype none
// tb_ram_burst_reader : directed bench with a registered-read RAM model.
module tb_ram_burst_reader;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic        Start;
  logic [9:0]  StartAddr;
  logic [10:0] Len;
  logic        Abort;
  logic        Busy;
  logic        Done;
  logic [9:0]  RA;
  logic        RClk_En;
  logic [15:0] RD = 16'h0000;
  logic [15:0] Out_Data;
  logic        Out_Valid;
  logic        Out_Ready;
  logic        Out_Last;

  int n_chk  = 0;
  int n_pass = 0;

  logic [15:0] mem [1024];

  always #5 Clk = ~Clk;

  ram_burst_reader #(.ADDR_W(10), .DATA_W(16)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Start(Start), .StartAddr(StartAddr), .Len(Len),
    .Abort(Abort), .Busy(Busy), .Done(Done), .RA(RA), .RClk_En(RClk_En),
    .RD(RD), .Out_Data(Out_Data), .Out_Valid(Out_Valid), .Out_Ready(Out_Ready),
    .Out_Last(Out_Last)
  );

  always @(posedge Clk) begin
    if (RClk_En) RD <= mem[RA];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // pat bit i is Out_Ready in cycle i after the start edge (1 afterwards).
  task automatic run_burst(input string name, input logic [9:0] addr, input logic [10:0] len,
                           input int n, input logic [7:0] pat, input int busy_start_cyc);
    int cyc, issued, acc, first_v, last_hs, done_cyc, budget;
    logic prev_stall, done_seen;
    logic [15:0] prev_data;
    logic [9:0] ea;
    cyc = 0; issued = 0; acc = 0; first_v = -1; last_hs = -10; done_cyc = -1;
    prev_stall = 1'b0; prev_data = '0; done_seen = 1'b0;
    budget = n * 4 + 20;
    Start = 1'b1; StartAddr = addr; Len = len; Out_Ready = 1'b1;
    step();
    while (!done_seen && cyc < budget) begin
      Out_Ready = (cyc < 8) ? pat[cyc] : 1'b1;
      if (cyc == busy_start_cyc) begin
        Start = 1'b1; StartAddr = 10'h155; Len = 11'd2;
      end else begin
        Start = 1'b0;
      end
      #1;
      if (cyc == 0) chk({name, "_busy0"}, Busy, 1);
      if (Done) begin
        done_seen = 1'b1;
        done_cyc  = cyc;
        chk({name, "_done_timing"}, cyc, last_hs + 1);
        chk({name, "_words"}, acc, n);
      end else begin
        if (RClk_En) begin
          ea = addr + 10'(issued);
          chk({name, "_ra"}, RA, ea);
          issued++;
        end
        if (prev_stall) begin
          chk({name, "_hold_valid"}, Out_Valid, 1);
          chk({name, "_hold_data"}, Out_Data, prev_data);
        end
        if (Out_Valid && first_v < 0) begin
          first_v = cyc;
          chk({name, "_latency"}, cyc, 2);
        end
        if (Out_Valid && Out_Ready) begin
          ea = addr + 10'(acc);
          chk({name, "_data"}, Out_Data, {6'd0, ea} ^ 16'hA5A5);
          chk({name, "_last"}, Out_Last, (acc == n - 1));
          acc++;
          last_hs = cyc;
        end
        chk({name, "_outstanding"}, (issued - acc) <= 2, 1);
        prev_stall = Out_Valid && !Out_Ready;
        prev_data  = Out_Data;
      end
      step();
      cyc++;
    end
    Start = 1'b0;
    if (!done_seen) chk({name, "_timeout"}, 0, 1);
    else if (pat == 8'hFF) chk({name, "_fullrate"}, done_cyc, n + 2);
    chk({name, "_idle_busy"}, Busy, 0);
    chk({name, "_idle_done"}, Done, 0);
  endtask

  task automatic chk_outputs_zero(input string name);
    chk({name, "_busy"}, Busy, 0);
    chk({name, "_done"}, Done, 0);
    chk({name, "_rclk_en"}, RClk_En, 0);
    chk({name, "_valid"}, Out_Valid, 0);
    chk({name, "_last"}, Out_Last, 0);
    chk({name, "_ra"}, RA, 0);
    chk({name, "_data"}, Out_Data, 0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 16'(i) ^ 16'hA5A5;
    Rst_n = 1'b0; Start = 1'b0; StartAddr = '0; Len = '0; Abort = 1'b0; Out_Ready = 1'b1;
    #2;
    chk_outputs_zero("reset");
    #10 Rst_n = 1'b1;
    step();

    run_burst("basic", 10'h010, 11'd4, 4, 8'hFF, -1);
    run_burst("wrap", 10'h3FE, 11'd4, 4, 8'hFF, -1);
    run_burst("bp", 10'h0A0, 11'd8, 8, 8'hE9, -1);

    // Zero-length burst: one Busy/Done cycle, no reads.
    Start = 1'b1; StartAddr = 10'h123; Len = 11'd0;
    step();
    Start = 1'b0;
    #1;
    chk("zero_done", Done, 1);
    chk("zero_busy", Busy, 1);
    chk("zero_rclk_en", RClk_En, 0);
    step();
    chk("zero_done_end", Done, 0);
    chk("zero_busy_end", Busy, 0);
    chk("zero_rclk_en_end", RClk_En, 0);

    run_burst("busy_start", 10'h300, 11'd6, 6, 8'hFF, 2);

    // Abort together with Start in idle: nothing starts.
    Start = 1'b1; Abort = 1'b1; Len = 11'd3; StartAddr = 10'h050;
    step();
    Start = 1'b0; Abort = 1'b0;
    #1;
    chk("abort_start_busy", Busy, 0);
    chk("abort_start_rclk_en", RClk_En, 0);

    // Abort mid-burst with a word buffered and one read still returning.
    Start = 1'b1; StartAddr = 10'h080; Len = 11'd16; Out_Ready = 1'b0;
    step();
    Start = 1'b0;
    #1;
    chk("abort_issue0", RClk_En, 1);
    step();
    chk("abort_issue1", RClk_En, 1);
    step();
    Abort = 1'b1;
    #1;
    chk("abort_pre_valid", Out_Valid, 1);
    step();
    Abort = 1'b0;
    #1;
    chk("abort_busy", Busy, 0);
    chk("abort_valid", Out_Valid, 0);
    chk("abort_rclk_en", RClk_En, 0);
    chk("abort_done", Done, 0);
    step();
    chk("abort_discard_valid", Out_Valid, 0);
    chk("abort_discard_done", Done, 0);
    Out_Ready = 1'b1;
    run_burst("post_abort", 10'h2C3, 11'd1, 1, 8'hFF, -1);

    // Asynchronous reset in the middle of a burst.
    Start = 1'b1; StartAddr = 10'h040; Len = 11'd16; Out_Ready = 1'b1;
    step();
    Start = 1'b0;
    for (int i = 0; i < 4; i++) step();
    Rst_n = 1'b0;
    #1;
    chk_outputs_zero("midrst");
    #2 Rst_n = 1'b1;
    step();
    run_burst("full", 10'h000, 11'h400, 1024, 8'hFF, -1);
    run_burst("sat", 10'h200, 11'h7FF, 1024, 8'hFF, -1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
